// File: rtl/cla_word_sequencer.sv
// Multi-cycle word adder that walks an external 8-bit CLA slice LSB-first,
// chaining the slice carry and presenting sum/cout/ovf with a one-cycle done.
module cla_word_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int SLICE_W    = 8,
  localparam int W         = SLICE_W * WORD_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic               cin_in,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_z,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       sum,
  output logic               cout,
  output logic               ovf
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [IW-1:0] idx;
  logic [W-1:0] a_r, b_r, part_r, part_nx;
  logic         carry_r;
  logic         run, last;

  assign run  = (state == S_RUN);
  assign last = (idx == IW'(WORD_BYTES - 1));
  assign busy = run;
  assign done = (state == S_DONE);

  assign add_a   = run ? a_r[SLICE_W*idx +: SLICE_W] : '0;
  assign add_b   = run ? b_r[SLICE_W*idx +: SLICE_W] : '0;
  assign add_cin = run ? carry_r : 1'b0;

  // Partial sum with the slice currently on the CLA merged in, so the
  // completing edge can load the full word in one step.
  always_comb begin
    part_nx = part_r;
    part_nx[SLICE_W*idx +: SLICE_W] = add_z;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      part_r  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          part_r  <= part_nx;
          carry_r <= add_cout;
          if (last) begin
            sum   <= part_nx;
            cout  <= add_cout;
            ovf   <= (a_r[W-1] == b_r[W-1]) && (part_nx[W-1] != a_r[W-1]);
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          // IDLE and DONE accept identically, which gives back-to-back issue.
          if (start) begin
            a_r     <= op_a;
            b_r     <= op_b;
            carry_r <= cin_in;
            idx     <= '0;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Scoreboard bench: a behavioural 8-bit CLA closes the loop, directed ops
// push expected results, and a negedge monitor checks every done.
module tb_cla_word_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, cin_in;
  logic [31:0] op_a, op_b, sum;
  logic [7:0]  add_a, add_b, add_z;
  logic        add_cin, add_cout, busy, done, cout, ovf;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0]  sl_a[16];
  logic        sl_cin[16];
  logic [31:0] sl_sum[16];
  int          nbusy, done_at;

  always #5 clk = ~clk;

  cla_word_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .cin_in(cin_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Behavioural CLA slice
  assign {add_cout, add_z} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pops one expected result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(1'b0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.o));
        end
      end
      if (done && prev_done) chk("done_width", 32'(prev_done), 32'(1'b0));
      if (done && busy) chk("busy_done_overlap", 32'(busy), 32'(1'b0));
    end
    prev_done = done;
  end

  // Issue one op, record the slice traffic, return on the done negedge.
  // poke_at >= 0 re-asserts start with other operands during RUN.
  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic c,
                    input logic [31:0] es, input logic ec, input logic eo,
                    input int poke_at);
    bit got;
    exp_q.push_back('{es, ec, eo});
    op_a = a; op_b = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; done_at = -1; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (busy && nbusy < 16) begin
        sl_a[nbusy] = add_a; sl_cin[nbusy] = add_cin; sl_sum[nbusy] = sum;
        nbusy++;
      end
      if (done) begin
        got = 1; done_at = i;
      end else begin
        if (i == poke_at) begin
          op_a = 32'd97; op_b = 32'd143; cin_in = 1'b0; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'(got), 32'(1));
    chk("busy_cycles", nbusy, 32'd4);
    chk("latency", done_at, 32'd4);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic add
    go(32'd10, 32'd6, 1'b0, 32'd16, 1'b0, 1'b0, -1);
    chk("basic_add_a", {sl_a[0], sl_a[1], sl_a[2], sl_a[3]}, 32'h0A000000);
    @(negedge clk);
    chk("idle_add_a", 32'(add_a), 32'd0);

    // Carry chain
    go(32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, -1);
    chk("chain_cin", {28'd0, sl_cin[0], sl_cin[1], sl_cin[2], sl_cin[3]}, 32'b0111);
    go(32'h000000FF, 32'd0, 1'b1, 32'h00000100, 1'b0, 1'b0, -1);
    chk("cin_in_slice0", 32'(sl_cin[0]), 32'd1);

    // Signed overflow, both directions
    go(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, -1);
    go(32'h80000000, 32'h80000000, 1'b0, 32'd0, 1'b1, 1'b1, -1);

    // Ignored start in RUN, then back-to-back on the done cycle
    go(32'd43, 32'd22, 1'b0, 32'd65, 1'b0, 1'b0, 1);
    go(32'd42, 32'd88, 1'b0, 32'd130, 1'b0, 1'b0, -1);
    chk("hold_sum_first", sl_sum[0], 32'd65);
    chk("hold_sum_last", sl_sum[3], 32'd65);
    @(negedge clk);

    // Reset mid-operation: no done may follow
    op_a = 32'h12345678; op_b = 32'h11111111; cin_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    go(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, -1);

    // Random, back-to-back against a 33-bit reference add
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a, b;
      logic        c;
      logic [32:0] r;
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      r = {1'b0, a} + {1'b0, b} + {32'd0, c};
      go(a, b, c, r[31:0], r[32], (a[31] == b[31]) && (r[31] != a[31]), -1);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-cycle 32-bit adder controller that sits directly upstream of the 8-bit carry-lookahead adder (the `main` CLA slice). It feeds the CLA one byte slice per clock and also consumes the slice's result. It latches a word-wide operand pair and walks the byte slices LSB-first, chaining the slice carry-out into the next slice's carry-in. It then presents the assembled sum, carry-out and signed-overflow flag with a one-cycle `done` strobe.

## Interface
- `WORD_BYTES`, default 4: number of 8-bit slices per operation. Word width W = 8*WORD_BYTES; legal range 1..8.
- `SLICE_W`, default 8: CLA slice width. Fixed at 8; it must match the adder's `width`.

- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-low reset. It is sampled on `clk` rising edge; 0 = reset.
- `start` input 1: request strobe. Accepted only in IDLE or DONE.
- `op_a` input W: operand A, latched on accept.
- `op_b` input W: operand B, latched on accept.
- `cin_in` input 1: carry into slice 0, latched on accept.
- `add_a` output 8: slice operand A to CLA `a`.
- `add_b` output 8: slice operand B to CLA `b`.
- `add_cin` output 1: slice carry to CLA `cin`.
- `add_z` input 8: CLA sum `z`. Combinational return, same cycle.
- `add_cout` input 1: CLA carry `cout`. Combinational return, same cycle.
- `busy` output 1: high while slices are being processed.
- `done` output 1: one-cycle completion strobe.
- `sum` output W: final sum. Held until the next completion.
- `cout` output 1: carry out of the top slice.
- `ovf` output 1: two's-complement overflow of the W-bit add.

## Operation
- **FSM states:** IDLE, RUN, DONE. The slice index `idx` runs 0..WORD_BYTES-1. Internal registers are `a_r`, `b_r`, `carry_r` and `part_r` (all W or 1 bit).
- **IDLE:**
  - `start`=1 → latch `op_a`, `op_b`, `cin_in` into `a_r`, `b_r`, `carry_r`; set `idx`=0; go to RUN.
  - Otherwise stay in IDLE.
- **RUN, slice driving (combinational from registers):** `add_a`=`a_r[8*idx +: 8]`, `add_b`=`b_r[8*idx +: 8]`, `add_cin`=`carry_r`.
- **RUN, each edge:**
  - `part_r[8*idx +: 8]` ← `add_z`.
  - `carry_r` ← `add_cout`.
  - If `idx`=WORD_BYTES-1: load `sum` ← assembled `part_r` (including the current slice), `cout` ← `add_cout`, `ovf` ← (`a_r[W-1]`==`b_r[W-1]`) && (new `sum[W-1]`≠`a_r[W-1]`); go to DONE.
  - Else `idx`++.
- **DONE:**
  - `done`=1 for this cycle only.
  - `start`=1 → accept a new operation exactly as from IDLE (back-to-back), going to RUN.
  - Otherwise go to IDLE.
- **`start` in RUN:** ignored. No queuing, and latched operands are unaffected.
- **Outside RUN:** `add_a`, `add_b`, `add_cin` are driven 0.
- **Result stability:** `sum`, `cout` and `ovf` change only on the completing edge. They stay stable through `busy` of a following operation.
- **Arithmetic:** unsigned W-bit add with carry-in. `sum` = (`op_a`+`op_b`+`cin_in`) mod 2^W, and `cout` = bit W of that sum.
- **Reset (`reset`=0 at an edge), from any state including mid-RUN:**
  - State → IDLE.
  - `idx`, `a_r`, `b_r`, `carry_r`, `part_r`, `sum`, `cout`, `ovf` → 0.
  - `busy`=0 and `done`=0.
  - Any in-flight operation is discarded with no `done`.

## Timing
- **Accept:** `start` is sampled at edge E0 (state IDLE or DONE). `busy`=1 from after E0 through edge E(WORD_BYTES).
- **Slice k:** presented on `add_*` during the cycle after E(k) and captured at E(k+1), for k = 0..WORD_BYTES-1.
- **Completion:** `sum`, `cout`, `ovf` are updated at E(WORD_BYTES). `done`=1 during the cycle following E(WORD_BYTES).
- **Latency:** start-to-done is WORD_BYTES+1 cycles; 5 cycles at the default.
- **Throughput:** back-to-back `start` on the `done` cycle gives one result every WORD_BYTES+1 cycles.
- **CLA path:** one combinational pass through the CLA per cycle. The critical path is register → CLA → `part_r`/`carry_r`.
- **Output values:** `busy` and `done` are registered state decodes and are never high together. Both are 0 after reset.

## Test plan
- **Basic add:** reset low for 2 cycles, then `op_a`=10, `op_b`=6, `cin_in`=0, `start` pulse → `busy` for 4 cycles, `done` on cycle 5, `sum`=16, `cout`=0, `ovf`=0. Check `add_a` sequence 0x0A,0x00,0x00,0x00.
- **Carry chain:** `op_a`=0xFFFFFFFF, `op_b`=1 → `sum`=0, `cout`=1, `ovf`=0. `add_cin` must be 0,1,1,1 across slices. Also `op_a`=0x000000FF, `op_b`=0, `cin_in`=1 → `sum`=0x00000100.
- **Signed overflow:** `op_a`=0x7FFFFFFF, `op_b`=1 → `sum`=0x80000000, `cout`=0, `ovf`=1. Then `op_a`=0x80000000, `op_b`=0x80000000 → `sum`=0, `cout`=1, `ovf`=1.
- **Back-to-back and ignored start:** `start` with 43+22, re-assert `start` during RUN with 97+143 (must be ignored) → `sum`=65. Assert `start` on the `done` cycle with 42+88 → next `done` exactly 5 cycles later with `sum`=130. `sum` holds 65 meanwhile.
- **Reset mid-operation:** start 0x12345678+0x11111111, drop `reset` at slice 2 → next cycle `busy`=0, `sum`=0, no `done` ever. A fresh start afterwards returns 0x23456789.
- **Random:** 1000 random `op_a`/`op_b`/`cin_in` with a scoreboard against a 33-bit reference add, plus checks of `ovf` and that `done` is exactly one cycle wide.
